// File: rtl/weight_ram_reader.sv
// weight_ram_reader
//   Read sequencer between the weight SRAM and the PE array. A command reads
//   a window of `length` words starting at `base_addr`, repeated `reps`
//   times. SRAM read latency is absorbed by a 2-entry output buffer, and
//   words leave on an AXI-Stream style master port at full rate.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start; command fields latched on start
//   RUN    | issuing reads, one per cycle while the buffer has room
//   DRAIN  | all reads issued; waiting for buffer and in-flight read
//   FINISH | done pulse, back to IDLE
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   start                  one-cycle command pulse (honoured in IDLE only)
//   base_addr/length/reps  command window, words per pass, pass count
//   busy, done             command in progress / one-cycle completion pulse
//   ram_en, ram_addr       SRAM read port (read data one cycle later)
//   ram_dout               SRAM read data
//   m_valid/m_ready        stream handshake
//   m_data, m_last         stream word, last word of the current pass
module weight_ram_reader #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 64,
  parameter int REPS_BITS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(DEPTH)-1:0]   base_addr,
  input  logic [$clog2(DEPTH):0]     length,
  input  logic [REPS_BITS-1:0]       reps,
  output logic                       busy,
  output logic                       done,
  output logic                       ram_en,
  output logic [$clog2(DEPTH)-1:0]   ram_addr,
  input  logic [WIDTH-1:0]           ram_dout,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [WIDTH-1:0]           m_data,
  output logic                       m_last
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FINISH} state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        base_q, base_d;
  logic [AW:0]          len_q, len_d;
  logic [REPS_BITS-1:0] rep_q, rep_d;
  logic [AW:0]          idx_q, idx_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic                 inflight_q, inflight_d;
  logic                 inflight_last_q, inflight_last_d;
  logic [1:0]           occ_q, occ_d;
  logic [WIDTH-1:0]     data0_q, data0_d, data1_q, data1_d;
  logic                 last0_q, last0_d, last1_q, last1_d;

  logic                 pop;
  logic [1:0]           fill;
  logic                 idx_last;
  logic [AW-1:0]        addr_inc;
  logic                 ram_en_c;

  assign pop      = (occ_q != 2'd0) && m_ready;
  assign fill     = occ_q + {1'b0, inflight_q};
  assign idx_last = (idx_q == (len_q - 1'b1));
  // explicit wrap so non-power-of-2 depths stay inside the array
  assign addr_inc = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + 1'b1;

  // A read may be issued into a full slot only when a pop frees it this
  // cycle; this keeps full rate under m_ready=1 without a third entry.
  assign ram_en_c = (state_q == S_RUN) &&
                    ((fill < 2'd2) || ((fill == 2'd2) && pop));

  always_comb begin
    occ_d   = occ_q;
    data0_d = data0_q;
    data1_d = data1_q;
    last0_d = last0_q;
    last1_d = last1_q;
    case ({inflight_q, pop})
      2'b01: begin
        data0_d = data1_q;
        last0_d = last1_q;
        occ_d   = occ_q - 2'd1;
      end
      2'b10: begin
        if (occ_q == 2'd0) begin
          data0_d = ram_dout;
          last0_d = inflight_last_q;
        end else begin
          data1_d = ram_dout;
          last1_d = inflight_last_q;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          data0_d = ram_dout;
          last0_d = inflight_last_q;
        end else begin
          data0_d = data1_q;
          last0_d = last1_q;
          data1_d = ram_dout;
          last1_d = inflight_last_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    base_d          = base_q;
    len_d           = len_q;
    rep_d           = rep_q;
    idx_d           = idx_q;
    addr_d          = addr_q;
    inflight_d      = ram_en_c;
    inflight_last_d = ram_en_c && idx_last;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d = base_addr;
          len_d  = length;
          rep_d  = reps;
          idx_d  = '0;
          addr_d = base_addr;
          // empty commands pass through DRAIN so done keeps a fixed offset
          if ((length == '0) || (reps == '0)) state_d = S_DRAIN;
          else                                state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (ram_en_c) begin
          if (idx_last) begin
            idx_d  = '0;
            addr_d = base_q;
            rep_d  = rep_q - 1'b1;
            if (rep_q == REPS_BITS'(1)) state_d = S_DRAIN;
          end else begin
            idx_d  = idx_q + 1'b1;
            addr_d = addr_inc;
          end
        end
      end
      S_DRAIN: begin
        // look at next occupancy so done lands right after the final pop
        if (occ_d == 2'd0) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      base_q          <= '0;
      len_q           <= '0;
      rep_q           <= '0;
      idx_q           <= '0;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      occ_q           <= 2'd0;
      data0_q         <= '0;
      data1_q         <= '0;
      last0_q         <= 1'b0;
      last1_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      base_q          <= base_d;
      len_q           <= len_d;
      rep_q           <= rep_d;
      idx_q           <= idx_d;
      addr_q          <= addr_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      occ_q           <= occ_d;
      data0_q         <= data0_d;
      data1_q         <= data1_d;
      last0_q         <= last0_d;
      last1_q         <= last1_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_FINISH);
  assign ram_en   = ram_en_c;
  assign ram_addr = addr_q;
  assign m_valid  = (occ_q != 2'd0);
  assign m_data   = data0_q;
  assign m_last   = last0_q;

endmodule

// File: tb/tb_weight_ram_reader.sv
// Bench for weight_ram_reader: SRAM model, event logger, and directed plus
// random commands checked against an arithmetic model of the stream.
module tb_weight_ram_reader;
  localparam int DEPTH = 10;
  localparam int WIDTH = 16;
  localparam int REPS_BITS = 8;
  localparam int AW = $clog2(DEPTH);

  logic                 clk = 1'b0;
  logic                 rst, start, m_ready;
  logic [AW-1:0]        base_addr;
  logic [AW:0]          length;
  logic [REPS_BITS-1:0] reps;
  logic                 busy, done, ram_en, m_valid, m_last;
  logic [AW-1:0]        ram_addr;
  logic [WIDTH-1:0]     ram_dout, m_data;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  weight_ram_reader #(.DEPTH(DEPTH), .WIDTH(WIDTH), .REPS_BITS(REPS_BITS)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .length(length), .reps(reps), .busy(busy), .done(done),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk)
    if (ram_en) ram_dout <= (int'(ram_addr) < DEPTH) ? mem[ram_addr] : 'x;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // event logs filled at the falling edge
  int               en_cyc[$], en_addr[$], bt_cyc[$], dn_cyc[$], bf_cyc[$];
  logic [WIDTH-1:0] bt_data[$];
  logic             bt_last[$];
  int               out_cnt = 0;
  logic             prev_busy = 1'b0, prev_hold = 1'b0, prev_last = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      out_cnt   <= 0;
      prev_hold <= 1'b0;
      prev_busy <= 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, prev_data);
        chk("hold_last", m_last, prev_last);
      end
      if (ram_en && !(m_valid && m_ready)) chk("issue_room", out_cnt < 2, 1);
      if (out_cnt > 0) chk("occ_max2", out_cnt <= 2, 1);
      if (ram_en) begin
        en_cyc.push_back(cyc);
        en_addr.push_back(int'(ram_addr));
      end
      if (m_valid && m_ready) begin
        bt_cyc.push_back(cyc);
        bt_data.push_back(m_data);
        bt_last.push_back(m_last);
      end
      if (done) dn_cyc.push_back(cyc);
      if (prev_busy && !busy) bf_cyc.push_back(cyc);
      out_cnt   <= out_cnt + int'(ram_en) - int'(m_valid && m_ready);
      prev_busy <= busy;
      prev_hold <= m_valid && !m_ready;
      prev_data <= m_data;
      prev_last <= m_last;
    end
  end

  task automatic clear_logs();
    en_cyc.delete(); en_addr.delete(); bt_cyc.delete(); bt_data.delete();
    bt_last.delete(); dn_cyc.delete(); bf_cyc.delete();
  endtask

  task automatic run_cmd(input int b, input int l, input int r, input int pct,
                         input bit inject, output int t0);
    clear_logs();
    base_addr = AW'(b);
    length    = (AW+1)'(l);
    reps      = REPS_BITS'(r);
    start     = 1'b1;
    m_ready   = (int'($urandom_range(0, 99)) < pct);
    t0 = cyc;
    for (int k = 0; k < 600 && bf_cyc.size() == 0; k++) begin
      step();
      start = inject && (cyc == t0 + 3);
      if (start) begin
        base_addr = AW'(1);
        length    = (AW+1)'(2);
        reps      = REPS_BITS'(1);
      end
      m_ready = (int'($urandom_range(0, 99)) < pct);
    end
    chk("cmd_end", bf_cyc.size(), 1);
    start   = 1'b0;
    m_ready = 1'b0;
    step();
    step();
  endtask

  // reference: pass p, word i -> mem[(b+i) mod DEPTH], last when i==l-1
  task automatic verify(input int b, input int l, input int r, input int t0, input bit full);
    int n, m, ed;
    n = l * r;
    chk("en_count", en_cyc.size(), n);
    m = (en_cyc.size() < n) ? en_cyc.size() : n;
    for (int i = 0; i < m; i++) begin
      chk("en_addr", en_addr[i], (b + i % l) % DEPTH);
      if (full) chk("en_cycle", en_cyc[i], t0 + 1 + i);
    end
    chk("beat_count", bt_cyc.size(), n);
    m = (bt_cyc.size() < n) ? bt_cyc.size() : n;
    for (int i = 0; i < m; i++) begin
      chk("beat_data", bt_data[i], mem[(b + i % l) % DEPTH]);
      chk("beat_last", bt_last[i], (i % l) == (l - 1));
      if (full) chk("beat_cycle", bt_cyc[i], t0 + 3 + i);
    end
    chk("done_count", dn_cyc.size(), 1);
    if (dn_cyc.size() > 0) begin
      ed = (n == 0) ? t0 + 2 : ((bt_cyc.size() > 0) ? bt_cyc[bt_cyc.size()-1] + 1 : -1);
      chk("done_cycle", dn_cyc[0], ed);
      if (bf_cyc.size() > 0) chk("busy_fall", bf_cyc[0], dn_cyc[0] + 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, b, l, r, pct;
    rst = 1'b1; start = 1'b0; m_ready = 1'b0;
    base_addr = '0; length = '0; reps = '0;
    foreach (mem[i]) mem[i] = WIDTH'($urandom);
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    rst = 1'b0;
    step();
    step();

    run_cmd(5, 4, 1, 100, 0, t0);
    verify(5, 4, 1, t0, 1);
    chk("basic_done_t7", (dn_cyc.size() > 0) ? dn_cyc[0] : -1, t0 + 7);

    run_cmd(0, 3, 3, 100, 1, t0);
    verify(0, 3, 3, t0, 1);

    run_cmd(8, 4, 1, 100, 0, t0);
    verify(8, 4, 1, t0, 1);

    for (int k = 0; k < 2; k++) begin
      b = int'($urandom_range(0, DEPTH - 1));
      r = int'($urandom_range(1, 2));
      run_cmd(b, 16, r, 30, 0, t0);
      verify(b, 16, r, t0, 0);
    end

    run_cmd(3, 0, 2, 100, 0, t0);
    verify(3, 0, 2, t0, 1);
    run_cmd(3, 5, 0, 100, 0, t0);
    verify(3, 5, 0, t0, 1);

    // reset with two beats taken and two entries buffered
    clear_logs();
    base_addr = AW'(2); length = (AW+1)'(4); reps = REPS_BITS'(1);
    start = 1'b1; m_ready = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 20 && bt_cyc.size() < 2; k++) step();
    m_ready = 1'b0;
    step();
    step();
    chk("prerst_valid", m_valid, 1);
    chk("prerst_beats", bt_cyc.size(), 2);
    rst = 1'b1;
    step();
    chk("midrst_valid", m_valid, 0);
    chk("midrst_ram_en", ram_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    rst = 1'b0;
    repeat (6) step();
    chk("midrst_no_done", dn_cyc.size(), 0);

    run_cmd(5, 4, 1, 100, 0, t0);
    verify(5, 4, 1, t0, 1);
    chk("basic2_done_t7", (dn_cyc.size() > 0) ? dn_cyc[0] : -1, t0 + 7);

    for (int k = 0; k < 4; k++) begin
      b   = int'($urandom_range(0, DEPTH - 1));
      l   = int'($urandom_range(1, 12));
      r   = int'($urandom_range(1, 3));
      pct = ($urandom_range(0, 1) == 1) ? 100 : 50;
      run_cmd(b, l, r, pct, 0, t0);
      verify(b, l, r, t0, pct == 100);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
